// File: rtl/variant_lut_pipe.sv
// Register-file lookup table with an INIT sweep that loads entry k = k,
// then serves one-cycle-latency lookups through a valid/ready output stage.
module variant_lut_pipe #(
    parameter int AW = 4,
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] nom,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] y,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    output logic          busy
);

    typedef enum logic {INIT, RUN} state_t;

    state_t        state, state_n;
    logic [AW-1:0] cnt;
    logic [DW-1:0] tbl [2**AW];
    logic [DW-1:0] initv;
    logic [AW+DW-1:0] wide;
    logic          accept;

    always_ff @(posedge clk) begin
        if (rst) state <= INIT;
        else     state <= state_n;
    end

    always_comb begin
        state_n  = state;
        busy     = 1'b0;
        in_ready = 1'b0;
        unique case (state)
            INIT: begin
                busy = 1'b1;
                if (cnt == {AW{1'b1}}) state_n = RUN;
            end
            RUN: begin
                in_ready = !out_valid || out_ready;
            end
            default: state_n = INIT;
        endcase
    end

    assign accept = in_valid && in_ready;

    // zero-extend or truncate the sweep index to the entry width
    assign wide  = {{DW{1'b0}}, cnt};
    assign initv = wide[DW-1:0];

    always_ff @(posedge clk) begin
        if (rst)                cnt <= '0;
        else if (state == INIT) cnt <= cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT) tbl[cnt]   <= initv;
            else if (we)       tbl[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            y         <= tbl[nom];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_variant_lut_pipe.sv
// Randomized and directed bench for variant_lut_pipe, scored against a
// table/flag reference model.
module tb_variant_lut_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] nom = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] y;
    logic       we = 1'b0;
    logic [3:0] waddr = '0;
    logic [3:0] wdata = '0;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] m_tbl [16];
    int         m_init_left = 16;
    logic       m_ov = 1'b0;
    logic [3:0] m_y = '0;
    logic [3:0] prog [16];

    variant_lut_pipe #(.AW(4), .DW(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .nom(nom),
        .out_valid(out_valid), .out_ready(out_ready), .y(y),
        .we(we), .waddr(waddr), .wdata(wdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input logic r, input logic iv, input logic [3:0] n,
                       input logic ordy, input logic w,
                       input logic [3:0] wa, input logic [3:0] wd);
        logic exp_rdy;
        rst = r; in_valid = iv; nom = n; out_ready = ordy;
        we = w; waddr = wa; wdata = wd;
        #1;
        exp_rdy = (m_init_left == 0) && (!m_ov || ordy);
        check("in_ready", in_ready, exp_rdy);
        @(posedge clk);
        if (r) begin
            m_init_left = 16;
            m_ov = 1'b0;
            m_y = '0;
        end else if (m_init_left > 0) begin
            m_tbl[16 - m_init_left] = 4'(16 - m_init_left);
            m_init_left--;
        end else begin
            if (iv && exp_rdy) begin
                m_y = m_tbl[n];
                m_ov = 1'b1;
            end else if (ordy) begin
                m_ov = 1'b0;
            end
            if (w) m_tbl[wa] = wd;
        end
        #1;
        check("busy", busy, m_init_left > 0);
        check("out_valid", out_valid, m_ov);
        check("y", y, m_y);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(0, 0, 0, 1, 0, 0, 0);
    endtask

    initial begin
        prog = '{4'hC, 4'h2, 4'h9, 4'hA, 4'h7, 4'h1, 4'hC, 4'h0,
                 4'hF, 4'h1, 4'h3, 4'hD, 4'h8, 4'hE, 4'hA, 4'h6};
        @(posedge clk); #1;

        cyc(1, 0, 0, 0, 0, 0, 0);
        check("rst_busy", busy, 1);
        idle(15);
        check("init_busy15", busy, 1);
        idle(1);
        check("init_done", busy, 0);

        cyc(0, 1, 4'h3, 1, 0, 0, 0);
        check("lk3", y, 4'h3);
        cyc(0, 1, 4'hF, 1, 0, 0, 0);
        check("lkF", y, 4'hF);
        check("lkF_ov", out_valid, 1);
        idle(1);
        check("drain_ov", out_valid, 0);

        for (int i = 0; i < 16; i++) cyc(0, 0, 0, 1, 1, 4'(i), prog[i]);
        for (int i = 0; i < 16; i++) begin
            cyc(0, 1, 4'(i), 1, 0, 0, 0);
            check("prog_rd", y, prog[i]);
        end
        idle(1);

        cyc(0, 1, 4'h8, 0, 0, 0, 0);
        check("stall_y0", y, prog[8]);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 4'h9, 0, 0, 0, 0);
            check("stall_y", y, prog[8]);
            check("stall_ov", out_valid, 1);
        end
        cyc(0, 1, 4'h9, 1, 0, 0, 0);
        check("stall_rel", y, prog[9]);
        idle(1);

        cyc(0, 1, 4'h5, 1, 1, 4'h5, 4'h9);
        check("rw_old", y, 4'h1);
        cyc(0, 1, 4'h5, 1, 0, 0, 0);
        check("rw_new", y, 4'h9);

        cyc(0, 0, 0, 1, 1, 4'h2, 4'hB);
        cyc(0, 1, 4'h2, 0, 0, 0, 0);
        check("pre_rst_y", y, 4'hB);
        cyc(1, 0, 0, 0, 0, 0, 0);
        check("rst_ov", out_valid, 0);
        check("rst_y", y, 0);
        for (int i = 0; i < 16; i++) cyc(0, 0, 0, 1, 1, 4'h2, 4'hE);
        check("rerun", busy, 0);
        cyc(0, 1, 4'h2, 1, 0, 0, 0);
        check("reinit_y", y, 4'h2);

        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 79) == 0),
                ($urandom_range(0, 3) != 0), 4'($urandom),
                ($urandom_range(0, 2) != 0),
                ($urandom_range(0, 2) == 0), 4'($urandom), 4'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/variant_lut_pipe.md
VARIANT_LUT_PIPE -- requirements
Module: variant_lut_pipe

Interface
REQ-001 The block SHALL have parameter AW, default 4, lookup index width; table depth is 2^AW entries.
REQ-002 The block SHALL have parameter DW, default 4, table entry / output data width.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RST  input  1  synchronous, active-high reset, sampled on rising edge of CLK.
REQ-005 IN_VALID  input  1  lookup request valid.
REQ-006 IN_READY  output  1  block accepts a lookup this cycle.
REQ-007 NOM  input  AW  lookup index.
REQ-008 OUT_VALID  output  1  Y holds a valid lookup result.
REQ-009 OUT_READY  input  1  downstream consumes Y this cycle.
REQ-010 Y  output  DW  lookup result, registered.
REQ-011 WE  input  1  table write enable.
REQ-012 WADDR  input  AW  table write index.
REQ-013 WDATA  input  DW  table write data.
REQ-014 BUSY  output  1  table initialisation in progress.

Function
REQ-015 The block SHALL hold a 2^AW x DW table in registers, one read port and one write port.
REQ-016 The block SHALL implement a two-state controller: INIT and RUN.
REQ-017 INIT SHALL write entry k = k (truncated or zero-extended to DW) at sweep counter k, one entry per cycle, k = 0 .. 2^AW-1.
REQ-018 INIT -> RUN SHALL occur on the edge that writes entry 2^AW-1; INIT therefore lasts exactly 2^AW cycles after RST deasserts.
REQ-019 BUSY SHALL be 1 in INIT and 0 in RUN.
REQ-020 In INIT, IN_READY SHALL be 0, and WE SHALL be ignored.
REQ-021 In RUN, IN_READY SHALL equal (!OUT_VALID || OUT_READY), combinationally.
REQ-022 A lookup SHALL be accepted on an edge where IN_VALID && IN_READY; Y SHALL then be loaded with table[NOM] and OUT_VALID set to 1, giving 1-cycle latency.
REQ-023 On an edge with OUT_VALID && OUT_READY and no new acceptance, OUT_VALID SHALL clear; Y SHALL hold its last value.
REQ-024 On an edge with OUT_VALID && OUT_READY and a new acceptance, OUT_VALID SHALL stay 1 and Y SHALL take the new result, so full throughput is one lookup per cycle.
REQ-025 While OUT_VALID && !OUT_READY, Y and OUT_VALID SHALL hold stable.
REQ-026 In RUN, WE=1 SHALL write WDATA into table[WADDR] on that edge.
REQ-027 A lookup and write on the same edge to the same index SHALL return the old entry; the new value SHALL be visible from the next accepted lookup.
REQ-028 Writes SHALL be accepted independently of the lookup handshake and of OUT_READY.
REQ-029 Inputs NOM, WADDR and WDATA SHALL be don't-care when their qualifier (IN_VALID / WE) is 0.

Reset
REQ-030 While RST=1 at an edge: state := INIT, sweep counter := 0, OUT_VALID := 0, Y := 0, BUSY output 1, IN_READY output 0.
REQ-031 RST asserted mid-sweep or mid-RUN SHALL abort any pending result, discard all table writes, and restart the full INIT sweep from entry 0 after RST deasserts.
REQ-032 Table contents SHALL NOT require a reset value beyond the INIT sweep.

Verification (AW=4, DW=4)
REQ-033 RST 1 cycle, then idle -> BUSY=1 for exactly 16 cycles, IN_READY=0 throughout, then BUSY=0, IN_READY=1.
REQ-034 After INIT, lookups NOM=0x3 then 0xF back-to-back with OUT_READY=1 -> Y=0x3 then 0xF on consecutive cycles, OUT_VALID=1 for 2 cycles.
REQ-035 Write program of C,2,9,A,7,1,C,0,F,1,3,D,8,E,A,6 to entries 0..F, then sweep NOM 0..F -> Y returns exactly that sequence.
REQ-036 Lookup NOM=0x8 with OUT_READY=0 for 3 cycles, IN_VALID held -> Y stable, OUT_VALID=1, IN_READY=0; OUT_READY=1 -> next result loads the following edge.
REQ-037 Same edge: WE=1 WADDR=0x5 WDATA=0x9 and lookup NOM=0x5 (entry 0x5 = 0x1) -> Y=0x1; next lookup NOM=0x5 -> Y=0x9.
REQ-038 RST pulsed during RUN with OUT_VALID=1 after writing entry 0x2=0xB -> OUT_VALID=0, BUSY=1 for 16 cycles, then lookup NOM=0x2 -> Y=0x2.
